// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the arbiter state encoding, the byte width and the grant-index width helper.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_HI,
        WAIT_LO
    } arb_state_t;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after rr_ptr, wrapping modulo N_REQ.
// Kept generic so other shared-resource arbiters can reuse it.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [idw(N_REQ)-1:0]  rr_ptr,
    output logic                   found,
    output logic [idw(N_REQ)-1:0]  idx
);

    localparam int IDW = idw(N_REQ);

    logic [IDW:0] cand;

    // Walk offsets from the far end down so the smallest offset from rr_ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (cand >= (IDW + 1)'(N_REQ)) begin
                cand = cand - (IDW + 1)'(N_REQ);
            end
            if (req_valid[cand[IDW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX serializer between N_REQ byte producers.
// Optional burst lock (keep the grant on a locking requester) is enabled with UART_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_lock,
    output logic [N_REQ-1:0]        req_ack,
    output logic                    tx_start,
    output logic [BYTE_W-1:0]       tx_byte,
    input  logic                    tx_busy,
    output logic [idw(N_REQ)-1:0]   grant_id,
    output logic                    active
);

    localparam int IDW   = idw(N_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   ptr_adv;
    logic [CNT_W-1:0] cnt;
    logic             pick_found;
    logic [IDW-1:0]   pick_idx;
    logic             grant;
    logic             hold;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    // Leftover or foreign tx_busy in IDLE blocks any new grant.
    assign grant   = (state == IDLE) && !tx_busy && pick_found;
    assign ptr_adv = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
    assign active  = (state != IDLE);

`ifdef UART_ARB_LOCK_EN
    assign hold = req_lock[grant_id] && req_valid[grant_id];
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign hold        = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT_HI;
            WAIT_HI: begin
                if (tx_busy) begin
                    state_next = WAIT_LO;
                end else if (cnt == CNT_W'(START_TIMEOUT)) begin
                    state_next = IDLE;
                end
            end
            WAIT_LO: if (!tx_busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_ack  <= '0;
            tx_start <= 1'b0;
            tx_byte  <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_next;
            req_ack  <= '0;
            tx_start <= (state == LAUNCH);
            if (grant) begin
                tx_byte  <= req_data[BYTE_W*pick_idx +: BYTE_W];
                grant_id <= pick_idx;
                req_ack  <= N_REQ'(1) << pick_idx;
            end
            // cnt counts WAIT_HI cycles after the tx_start cycle; a timed-out launch is not retried.
            if (state == LAUNCH) begin
                cnt <= '0;
            end else if (state == WAIT_HI && cnt != CNT_W'(START_TIMEOUT)) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == WAIT_LO && !tx_busy) begin
                rr_ptr <= hold ? grant_id : ptr_adv;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed producer streams, a UART_TX busy model and a decoupled monitor.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int TO    = 4;
    localparam int FRAME = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_ack;
    logic           tx_start;
    logic [7:0]     tx_byte;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           active;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ack   (req_ack),
        .tx_start  (tx_start),
        .tx_byte   (tx_byte),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Producers: main writes bytes/pwr, monitor advances prd on ack.
    logic [7:0] pbytes [N][16];
    int pwr [N] = '{default: 0};
    int prd [N] = '{default: 0};

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (pwr[i] != prd[i]);
            req_data[8*i +: 8] = pbytes[i][prd[i] & 15];
        end
    end

    // UART_TX model: busy for FRAME cycles after each tx_start, plus an external force.
    int   busy_cnt   = 0;
    logic model_busy = 1'b0;
    logic force_busy;
    logic model_en;
    assign tx_busy = force_busy | model_busy;

    always @(posedge clk) begin
        #1;
        if (busy_cnt > 0) busy_cnt--;
        if (tx_start === 1'b1 && model_en) busy_cnt = FRAME;
        model_busy = (busy_cnt > 0);
    end

    typedef struct {
        int         id;
        logic [7:0] b;
    } exp_t;

    exp_t ack_q[$];
    exp_t launch_q[$];

    int mchecks   = 0;
    int merrs     = 0;
    int ack_total = 0;
    int ack_cyc   = -1;
    int start_cyc = -1;
    exp_t me;

    always @(negedge clk) begin
        if (req_ack !== '0) begin
            ack_total++;
            ack_cyc = cyc;
            mchecks++;
            if (ack_q.size() == 0) begin
                merrs++;
                $display("FAIL ack_unexpected got %b want none", req_ack);
            end else begin
                me = ack_q.pop_front();
                if (req_ack !== (N'(1) << me.id)) begin
                    merrs++;
                    $display("FAIL ack_vector got %b want %b", req_ack, N'(1) << me.id);
                end
            end
            for (int i = 0; i < N; i++) if (req_ack[i] === 1'b1) prd[i] = prd[i] + 1;
        end
        if (tx_start === 1'b1) begin
            start_cyc = cyc;
            mchecks++;
            if (launch_q.size() == 0) begin
                merrs++;
                $display("FAIL launch_unexpected got id %0d byte %h want none", grant_id, tx_byte);
            end else begin
                me = launch_q.pop_front();
                if (grant_id !== 2'(me.id) || tx_byte !== me.b) begin
                    merrs++;
                    $display("FAIL launch got id %0d byte %h want id %0d byte %h",
                             grant_id, tx_byte, me.id, me.b);
                end
            end
        end
    end

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic load(input int id, input logic [7:0] b);
        pbytes[id][pwr[id] & 15] = b;
        pwr[id] = pwr[id] + 1;
    endtask

    task automatic expect_grant(input int id, input logic [7:0] b);
        exp_t e;
        e.id = id;
        e.b  = b;
        ack_q.push_back(e);
        launch_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack_q.size() == 0 && launch_q.size() == 0 && active === 1'b0 &&
                     tx_busy === 1'b0) && n < 400);
        if (n >= 400) begin
            checks++;
            errs++;
            $display("FAIL %s_timeout got pending %0d want 0", name, launch_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    int t0, t1, n0;

    initial begin
        rst        = 1'b1;
        force_busy = 1'b0;
        model_en   = 1'b1;
        req_lock   = '0;
        repeat (3) @(negedge clk);
        chk("rst_active", 32'(active), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_req_ack", 32'(req_ack), 0);
        chk("rst_tx_byte", 32'(tx_byte), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        rst = 1'b0;
        @(negedge clk);

        // All four pending from rr_ptr=0: 0,1,2,3 then 0 again.
        load(0, 8'hA0); load(1, 8'hA1); load(2, 8'hA2); load(3, 8'hA3); load(0, 8'hB0);
        expect_grant(0, 8'hA0); expect_grant(1, 8'hA1); expect_grant(2, 8'hA2);
        expect_grant(3, 8'hA3); expect_grant(0, 8'hB0);
        wait_idle("simul");

        // Single request latency.
        t0 = cyc;
        load(0, 8'h41);
        expect_grant(0, 8'h41);
        wait_idle("single");
        chk("single_ack_cycle", 32'(ack_cyc), 32'(t0 + 1));
        chk("single_start_cycle", 32'(start_cyc), 32'(t0 + 2));

        // Busy gating in IDLE.
        force_busy = 1'b1;
        n0 = ack_total;
        load(1, 8'h55);
        expect_grant(1, 8'h55);
        repeat (5) @(negedge clk);
        chk("busy_gate_noack", 32'(ack_total), 32'(n0));
        t1 = cyc;
        force_busy = 1'b0;
        wait_idle("busy_gate");
        chk("busy_gate_ack_cycle", 32'(ack_cyc), 32'(t1 + 1));

        // Start timeout: tx_busy never rises.
        model_en = 1'b0;
        n0 = ack_total;
        t0 = cyc;
        load(2, 8'h77);
        expect_grant(2, 8'h77);
        while (cyc < t0 + 6) @(negedge clk);
        chk("timeout_active_before", 32'(active), 1);
        @(negedge clk);
        chk("timeout_active_after", 32'(active), 0);
        repeat (8) @(negedge clk);
        chk("timeout_single_ack", 32'(ack_total - n0), 1);
        model_en = 1'b1;
        wait_idle("timeout");

        // Requester 2 with lock and three bytes against requester 0.
        req_lock = 4'b0100;
        load(2, 8'hC0); load(2, 8'hC1); load(2, 8'hC2); load(0, 8'hD0);
`ifdef UART_ARB_LOCK_EN
        expect_grant(2, 8'hC0); expect_grant(2, 8'hC1); expect_grant(2, 8'hC2);
        expect_grant(0, 8'hD0);
`else
        expect_grant(2, 8'hC0); expect_grant(0, 8'hD0); expect_grant(2, 8'hC1);
        expect_grant(2, 8'hC2);
`endif
        wait_idle("lock");
        req_lock = '0;

        // Reset while in WAIT_LO; UART frame keeps running.
        t0 = cyc;
        load(3, 8'h99);
        expect_grant(3, 8'h99);
        n0 = 0;
        while (start_cyc <= t0 && n0 < 20) begin
            @(negedge clk);
            n0++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_active", 32'(active), 0);
        chk("midrst_tx_start", 32'(tx_start), 0);
        chk("midrst_req_ack", 32'(req_ack), 0);
        chk("midrst_tx_byte", 32'(tx_byte), 0);
        chk("midrst_busy_still", 32'(tx_busy), 1);
        load(1, 8'h5A);
        expect_grant(1, 8'h5A);
        n0 = 0;
        while (tx_busy === 1'b1 && n0 < 40) begin
            @(negedge clk);
            n0++;
        end
        t1 = cyc;
        wait_idle("midrst");
        chk("midrst_regrant_cycle", 32'(ack_cyc), 32'(t1 + 1));

        $display("CHECKS %0d ERRORS %0d", checks + mchecks, errs + merrs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
